// File: rtl/color_bounce_sequencer.sv
// Color Bounce top-level controller: paces the updater per frame, latches its score and
// gameover results, and sequences the VGA drawer passes over a request/done handshake.
module color_bounce_sequencer #(
  parameter int unsigned TICK_CYCLES = 833333,
  parameter int unsigned SCORE_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_n,
  input  logic               gameover_in,
  input  logic [SCORE_W-1:0] next_score_in,
  input  logic               draw_done,
  output logic [1:0]         statesig,
  output logic               draw_req,
  output logic [1:0]         draw_sel,
  output logic [SCORE_W-1:0] curr_score,
  output logic               game_active,
  output logic               game_over
);

  localparam int unsigned CntW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  // Nine states do not fit in three bits, so the register is four bits wide.
  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StClear  = 4'd1,
    StWait   = 4'd2,
    StUpdate = 4'd3,
    StLatch  = 4'd4,
    StErase  = 4'd5,
    StBall   = 4'd6,
    StPlats  = 4'd7,
    StOver   = 4'd8
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [1:0]         statesig_q, statesig_d;
  logic               draw_req_q, draw_req_d;
  logic [1:0]         draw_sel_q, draw_sel_d;
  logic               active_q, active_d;
  logic               over_q, over_d;
  logic               start_s1_q, start_s2_q, start_s3_q;
  logic               start_fall;

  // start_s3_q holds the previous synchronised key level for press detection.
  assign start_fall = start_s3_q & ~start_s2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    score_d = score_q;
    case (state_q)
      StIdle: begin
        if (!start_s2_q) state_d = StClear;
      end
      StClear: begin
        if (draw_done) begin
          state_d = StWait;
          score_d = '0;
        end
      end
      StWait: begin
        if (cnt_q == CntLast) state_d = StUpdate;
        else                  cnt_d   = cnt_q + CntOne;
      end
      StUpdate: state_d = StLatch;
      StLatch: begin
        score_d = next_score_in;
        state_d = gameover_in ? StOver : StErase;
      end
      StErase: if (draw_done) state_d = StBall;
      StBall:  if (draw_done) state_d = StPlats;
      StPlats: if (draw_done) state_d = StWait;
      StOver:  if (start_fall) state_d = StClear;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode the next state so they are registered and valid on state entry.
  always_comb begin
    statesig_d = 2'b00;
    draw_req_d = 1'b0;
    draw_sel_d = 2'b00;
    active_d   = 1'b1;
    over_d     = 1'b0;
    case (state_d)
      StClear:  begin statesig_d = 2'b01; draw_req_d = 1'b1; draw_sel_d = 2'b00; end
      StWait:   statesig_d = 2'b10;
      StUpdate: statesig_d = 2'b11;
      StLatch:  statesig_d = 2'b10;
      StErase:  begin statesig_d = 2'b01; draw_req_d = 1'b1; draw_sel_d = 2'b01; end
      StBall:   begin statesig_d = 2'b01; draw_req_d = 1'b1; draw_sel_d = 2'b10; end
      StPlats:  begin statesig_d = 2'b01; draw_req_d = 1'b1; draw_sel_d = 2'b11; end
      StOver:   begin active_d = 1'b0; over_d = 1'b1; end
      default:  active_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      score_q    <= '0;
      statesig_q <= 2'b00;
      draw_req_q <= 1'b0;
      draw_sel_q <= 2'b00;
      active_q   <= 1'b0;
      over_q     <= 1'b0;
      start_s1_q <= 1'b1;
      start_s2_q <= 1'b1;
      start_s3_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      score_q    <= score_d;
      statesig_q <= statesig_d;
      draw_req_q <= draw_req_d;
      draw_sel_q <= draw_sel_d;
      active_q   <= active_d;
      over_q     <= over_d;
      start_s1_q <= start_n;
      start_s2_q <= start_s1_q;
      start_s3_q <= start_s2_q;
    end
  end

  assign statesig    = statesig_q;
  assign draw_req    = draw_req_q;
  assign draw_sel    = draw_sel_q;
  assign curr_score  = score_q;
  assign game_active = active_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_color_bounce_sequencer.sv
// Scoreboard bench for color_bounce_sequencer: each cycle's expected outputs are queued when
// stimulus is driven and popped for comparison after the clock edge.
module tb_color_bounce_sequencer;

  localparam int unsigned TickCycles = 8;
  localparam int unsigned ScoreW     = 32;

  // Bench-side state labels used only to build expected output tuples.
  localparam int BIdle = 0, BClear = 1, BWait = 2, BUpdate = 3, BLatch = 4;
  localparam int BErase = 5, BBall = 6, BPlats = 7, BOver = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_n;
  logic              gameover_in;
  logic [ScoreW-1:0] next_score_in;
  logic              draw_done;
  logic [1:0]        statesig;
  logic              draw_req;
  logic [1:0]        draw_sel;
  logic [ScoreW-1:0] curr_score;
  logic              game_active;
  logic              game_over;

  typedef struct {
    string       tag;
    logic [38:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  color_bounce_sequencer #(
    .TICK_CYCLES(TickCycles),
    .SCORE_W    (ScoreW)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start_n      (start_n),
    .gameover_in  (gameover_in),
    .next_score_in(next_score_in),
    .draw_done    (draw_done),
    .statesig     (statesig),
    .draw_req     (draw_req),
    .draw_sel     (draw_sel),
    .curr_score   (curr_score),
    .game_active  (game_active),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  // Packed as {score, statesig, draw_req, draw_sel, game_active, game_over}.
  function automatic logic [38:0] pack_exp(int st, logic [31:0] sc);
    logic [1:0] ss, sel;
    logic       req, act, ovr;
    ss = 2'b00; sel = 2'b00; req = 1'b0; act = 1'b1; ovr = 1'b0;
    case (st)
      BClear:  begin ss = 2'b01; req = 1'b1; sel = 2'b00; end
      BWait:   ss = 2'b10;
      BUpdate: ss = 2'b11;
      BLatch:  ss = 2'b10;
      BErase:  begin ss = 2'b01; req = 1'b1; sel = 2'b01; end
      BBall:   begin ss = 2'b01; req = 1'b1; sel = 2'b10; end
      BPlats:  begin ss = 2'b01; req = 1'b1; sel = 2'b11; end
      BOver:   begin act = 1'b0; ovr = 1'b1; end
      default: act = 1'b0;
    endcase
    return {sc, ss, req, sel, act, ovr};
  endfunction

  task automatic check_val(input string tag, input logic [38:0] obs, input logic [38:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got score=%h ss=%b req=%b sel=%b act=%b ovr=%b, want score=%h ss=%b req=%b sel=%b act=%b ovr=%b",
               tag, obs[38:7], obs[6:5], obs[4], obs[3:2], obs[1], obs[0],
               exp[38:7], exp[6:5], exp[4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // Push expectation for the state reached at the next edge, advance, then pop and compare.
  task automatic cyc(input string tag, input int st, input logic [31:0] sc);
    exp_t e;
    e.tag = tag;
    e.val = pack_exp(st, sc);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val(e.tag, {curr_score, statesig, draw_req, draw_sel, game_active, game_over}, e.val);
  endtask

  // Walk a full wait period starting from the first observed wait cycle.
  task automatic wait_period(input string tag, input logic [31:0] sc);
    for (int i = 1; i < TickCycles; i++) cyc(tag, BWait, sc);
    cyc({tag, "_upd"}, BUpdate, sc);
    cyc({tag, "_latch"}, BLatch, sc);
  endtask

  task automatic pulse_done(input string tag, input int st, input logic [31:0] sc);
    draw_done = 1'b1;
    cyc(tag, st, sc);
    draw_done = 1'b0;
  endtask

  task automatic quick_draws(input string tag, input logic [31:0] sc);
    pulse_done({tag, "_ball"}, BBall, sc);
    pulse_done({tag, "_plats"}, BPlats, sc);
    pulse_done({tag, "_wait"}, BWait, sc);
  endtask

  initial begin
    reset = 1'b1; start_n = 1'b1; gameover_in = 1'b0; next_score_in = '0; draw_done = 1'b0;
    cyc("reset", BIdle, 0);
    cyc("reset2", BIdle, 0);
    reset = 1'b0;
    cyc("idle", BIdle, 0);

    // Key press: two synchroniser cycles then clear pass.
    start_n = 1'b0;
    cyc("sync1", BIdle, 0);
    cyc("sync2", BIdle, 0);
    cyc("clear", BClear, 0);
    start_n = 1'b1;
    cyc("clear_hold", BClear, 0);
    cyc("clear_hold", BClear, 0);
    pulse_done("clear_done", BWait, 0);

    // Frame 1: score 5, stray draw_done in wait, long ball pass.
    next_score_in = 32'd5;
    draw_done = 1'b1;
    cyc("stray_done", BWait, 0);
    draw_done = 1'b0;
    for (int i = 2; i < TickCycles; i++) cyc("f1_wait", BWait, 0);
    cyc("f1_upd", BUpdate, 0);
    cyc("f1_latch", BLatch, 0);
    cyc("f1_erase", BErase, 5);
    cyc("f1_erase_hold", BErase, 5);
    pulse_done("f1_ball", BBall, 5);
    for (int i = 0; i < 100; i++) cyc("f1_ball_hold", BBall, 5);
    pulse_done("f1_plats", BPlats, 5);
    pulse_done("f1_wait", BWait, 5);

    // Frame 2: all-ones score; frame 3: updater wraps to zero.
    next_score_in = '1;
    wait_period("f2", 5);
    cyc("f2_erase", BErase, 32'hFFFF_FFFF);
    quick_draws("f2", 32'hFFFF_FFFF);
    next_score_in = '0;
    wait_period("f3", 32'hFFFF_FFFF);
    cyc("f3_erase", BErase, 0);
    quick_draws("f3", 0);

    // Frame 4: gameover with the key already held down.
    next_score_in = 32'd7;
    gameover_in = 1'b1;
    start_n = 1'b0;
    wait_period("f4", 0);
    cyc("over", BOver, 7);
    gameover_in = 1'b0;
    for (int i = 0; i < 10; i++) cyc("over_held", BOver, 7);
    start_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc("over_rel", BOver, 7);
    start_n = 1'b0;
    cyc("over_sync1", BOver, 7);
    cyc("over_sync2", BOver, 7);
    cyc("restart", BClear, 7);
    start_n = 1'b1;
    pulse_done("restart_done", BWait, 0);

    // Frame 5: reset while the platform pass is outstanding.
    next_score_in = 32'd3;
    wait_period("f5", 0);
    cyc("f5_erase", BErase, 3);
    pulse_done("f5_ball", BBall, 3);
    pulse_done("f5_plats", BPlats, 3);
    cyc("f5_plats_hold", BPlats, 3);
    reset = 1'b1;
    cyc("mid_reset", BIdle, 0);
    reset = 1'b0;
    cyc("post_reset", BIdle, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
